// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control unit.
//   - stallState_e : control FSM states (RUN, LSTALL, MWAIT)
//   - stallCtrl_t  : bundle of pipeline hold/flush/freeze enables
//   - CTRL_*       : canonical control words (normal flow, NOP bubble,
//                    full freeze, reset)
//   - RW_DEFAULT   : default register-index width
package hazard_stall_unit_pkg;

    localparam int RW_DEFAULT = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } stallState_e;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic idExBubble;
        logic ifIdFlush;
        logic pipeFreeze;
    } stallCtrl_t;

    // Instructions flow freely.
    localparam stallCtrl_t CTRL_NORMAL = '{pcWrite: 1'b1, ifIdWrite: 1'b1,
                                           idExBubble: 1'b0, ifIdFlush: 1'b0,
                                           pipeFreeze: 1'b0};
    // Hold PC and IF/ID, inject a NOP into ID/EX.
    localparam stallCtrl_t CTRL_BUBBLE = '{pcWrite: 1'b0, ifIdWrite: 1'b0,
                                           idExBubble: 1'b1, ifIdFlush: 1'b0,
                                           pipeFreeze: 1'b0};
    // Hold every pipeline register while data memory is busy.
    localparam stallCtrl_t CTRL_FREEZE = '{pcWrite: 1'b0, ifIdWrite: 1'b0,
                                           idExBubble: 1'b0, ifIdFlush: 1'b0,
                                           pipeFreeze: 1'b1};
    // During reset the front end holds and ID/EX is filled with NOPs.
    localparam stallCtrl_t CTRL_RESET  = CTRL_BUBBLE;

endpackage

// File: rtl/hazard_stall_unit_match.sv
// Register-dependency comparator (hazard_match).
// Ports:
//   exRd   in  RW  destination register of the EX-stage instruction
//   idRs   in  RW  rs source of the ID-stage instruction
//   idRt   in  RW  rt source of the ID-stage instruction
//   usesRt in  1   the ID-stage instruction actually reads rt
//   match  out 1   ID-stage instruction depends on the EX-stage result
// Register 0 is hard-wired zero and therefore never creates a dependency.
module hazard_match
    import hazard_stall_unit_pkg::*;
#(
    parameter int RW = RW_DEFAULT
) (
    input  logic [RW-1:0] exRd,
    input  logic [RW-1:0] idRs,
    input  logic [RW-1:0] idRt,
    input  logic          usesRt,
    output logic          match
);

    assign match = (exRd != '0) && ((exRd == idRs) || (usesRt && (exRd == idRt)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard / stall control unit.
// Detects load-use and ALU-to-branch hazards between the EX and ID stages,
// freezes the pipeline while data memory is busy, and issues the IF/ID flush
// for taken branches resolved in ID.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_ex_mem_read/reg_write/rd   EX-stage instruction info
//   if_id_rs/rt/uses_rt/branch    ID-stage instruction info
//   branch_taken                  ID-stage branch resolved taken
//   mem_busy                      data memory stalls this cycle
//   pc_write, if_id_write         hold-enables (0 = hold)
//   id_ex_bubble                  insert NOP into ID/EX
//   if_id_flush                   zero IF/ID on the next edge
//   pipe_freeze                   freeze every pipeline register
//   stall_events                  saturating count of cycles with pc_write=0
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int RW         = RW_DEFAULT,
    parameter int LOAD_STALL = 1,
    parameter int BR_IN_ID   = 1,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_ex_mem_read,
    input  logic          id_ex_reg_write,
    input  logic [RW-1:0] id_ex_rd,
    input  logic [RW-1:0] if_id_rs,
    input  logic [RW-1:0] if_id_rt,
    input  logic          if_id_uses_rt,
    input  logic          if_id_branch,
    input  logic          branch_taken,
    input  logic          mem_busy,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          id_ex_bubble,
    output logic          if_id_flush,
    output logic          pipe_freeze,
    output logic [CW-1:0] stall_events
);

    // Remaining bubbles after the first one, which is issued from RUN.
    localparam logic [1:0] LOAD_CNT = 2'(LOAD_STALL - 1);

    stallState_e state, nextState;
    logic [1:0]  cnt, nextCnt;
    stallCtrl_t  ctrl, ctrlOut;
    logic        match, loadHaz, brHaz;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    hazard_match #(.RW(RW)) uMatch (
        .exRd   (id_ex_rd),
        .idRs   (if_id_rs),
        .idRt   (if_id_rt),
        .usesRt (if_id_uses_rt),
        .match  (match)
    );

    assign loadHaz = id_ex_mem_read && match;
    assign brHaz   = (BR_IN_ID != 0) && if_id_branch && id_ex_reg_write
                     && !id_ex_mem_read && match;

    always_comb begin
        ctrl      = CTRL_NORMAL;
        nextState = state;
        nextCnt   = cnt;
        case (state)
            LSTALL: begin
                if (mem_busy) begin
                    // Memory stall wins; the pending bubbles are dropped and
                    // the hazard is re-evaluated once memory is free.
                    ctrl      = CTRL_FREEZE;
                    nextState = MWAIT;
                    nextCnt   = '0;
                end else begin
                    ctrl    = CTRL_BUBBLE;
                    nextCnt = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        nextState = RUN;
                    end
                end
            end
            default: begin
                // RUN, and the MWAIT exit cycle: the pipeline registers did
                // not move during the freeze, so the hazard inputs are still
                // live and must be evaluated normally here.
                if (mem_busy) begin
                    ctrl      = CTRL_FREEZE;
                    nextState = MWAIT;
                end else begin
                    nextState = RUN;
                    if (loadHaz) begin
                        ctrl = CTRL_BUBBLE;
                        if (LOAD_STALL > 1) begin
                            nextState = LSTALL;
                            nextCnt   = LOAD_CNT;
                        end
                    end else if (brHaz) begin
                        ctrl = CTRL_BUBBLE;
                    end else begin
                        // A taken branch is only honoured on a stall-free cycle.
                        ctrl.ifIdFlush = branch_taken;
                    end
                end
            end
        endcase
    end

    // Reset forces the front end to hold and ID/EX to NOPs immediately.
    assign ctrlOut      = rst_n ? ctrl : CTRL_RESET;
    assign pc_write     = ctrlOut.pcWrite;
    assign if_id_write  = ctrlOut.ifIdWrite;
    assign id_ex_bubble = ctrlOut.idExBubble;
    assign if_id_flush  = ctrlOut.ifIdFlush;
    assign pipe_freeze  = ctrlOut.pipeFreeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            stall_events <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (!ctrl.pcWrite) begin
                stall_events <= satInc(stall_events);
            end
        end
    end

endmodule
